// File: rtl/bank_port_initiator_if.sv
// Command, RAM-port and response signals of one bank_port_initiator.
// The slave modport is the initiator's view; master is the client/RAM side.
interface bank_port_initiator_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_we;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_wdata;
  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_din;
  logic [DATA_WIDTH-1:0] i_mem_dout;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic [ADDR_WIDTH-1:0] o_rsp_addr;
  logic                  o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_mem_dout, i_rsp_ready,
    output o_cmd_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
           o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_mem_dout, i_rsp_ready,
    input  o_cmd_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
           o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy
  );
endinterface

// File: rtl/bank_port_initiator.sv
// Initiator engine for one port of the banked dual-port RAM: issues registered
// strobes, tracks read latency, buffers responses and blocks read-after-write hazards.
module bank_port_initiator #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bank_port_initiator_if.slave bus
);
  localparam int CW  = $clog2(RSP_DEPTH + 1) + 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int AGW = $clog2(WRITE_LATENCY + 1);
  localparam int HPW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic [READ_LATENCY-1:0] trk_vld_q, trk_vld_d;
  logic [ADDR_WIDTH-1:0]   trk_addr_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   trk_addr_d [READ_LATENCY];
  logic                    cap_vld_q, cap_vld_d;
  logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_WIDTH-1:0]   cap_data_q, cap_data_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_d [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_addr_d [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [AGW-1:0]          haz_age_q [WRITE_LATENCY];
  logic [AGW-1:0]          haz_age_d [WRITE_LATENCY];
  logic [ADDR_WIDTH-1:0]   haz_addr_q [WRITE_LATENCY];
  logic [ADDR_WIDTH-1:0]   haz_addr_d [WRITE_LATENCY];
  logic [HPW-1:0]          haz_ptr_q, haz_ptr_d;

  logic [CW-1:0] inflight_s;
  logic          credit_ok_s, haz_match_s, haz_live_s;
  logic          cmd_ready_s, accept_s, rsp_valid_s, pop_s;

  function automatic logic [PW-1:0] rsp_ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  function automatic logic [HPW-1:0] haz_ptr_inc(input logic [HPW-1:0] p);
    if (p == HPW'(WRITE_LATENCY - 1)) begin
      return {HPW{1'b0}};
    end else begin
      return p + HPW'(1);
    end
  endfunction

  // Credit and hazard status; an entry of age 1 expires at the coming edge, so it no longer blocks.
  always_comb begin
    inflight_s = CW'(mem_en_q & ~mem_we_q) + CW'(cap_vld_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + CW'(trk_vld_q[i]);
    end
    haz_match_s = 1'b0;
    haz_live_s  = 1'b0;
    for (int i = 0; i < WRITE_LATENCY; i++) begin
      haz_match_s = haz_match_s | ((haz_age_q[i] > AGW'(1)) & (haz_addr_q[i] == bus.i_cmd_addr));
      haz_live_s  = haz_live_s | (haz_age_q[i] != {AGW{1'b0}});
    end
    credit_ok_s = (inflight_s + count_q) < CW'(RSP_DEPTH);
    cmd_ready_s = ~i_rst & (bus.i_cmd_we | (credit_ok_s & ~haz_match_s));
    accept_s    = bus.i_cmd_valid & cmd_ready_s;
    rsp_valid_s = (count_q != {CW{1'b0}});
    pop_s       = rsp_valid_s & bus.i_rsp_ready;
  end

  // Issue strobes and the read-latency tracking pipe.
  always_comb begin
    mem_en_d   = accept_s;
    mem_we_d   = accept_s & bus.i_cmd_we;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (accept_s) begin
      mem_addr_d = bus.i_cmd_addr;
      if (bus.i_cmd_we) begin
        mem_din_d = bus.i_cmd_wdata;
      end else begin
        mem_din_d = mem_din_q;
      end
    end else begin
      mem_addr_d = mem_addr_q;
    end
    trk_vld_d[0]  = mem_en_q & ~mem_we_q;
    trk_addr_d[0] = mem_addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      trk_vld_d[i]  = trk_vld_q[i-1];
      trk_addr_d[i] = trk_addr_q[i-1];
    end
    cap_vld_d  = trk_vld_q[READ_LATENCY-1];
    cap_addr_d = trk_addr_q[READ_LATENCY-1];
    if (trk_vld_q[READ_LATENCY-1]) begin
      cap_data_d = bus.i_mem_dout;
    end else begin
      cap_data_d = cap_data_q;
    end
  end

  // Response FIFO and hazard tracker next state.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (cap_vld_q) begin
      fifo_data_d[wr_ptr_q] = cap_data_q;
      fifo_addr_d[wr_ptr_q] = cap_addr_q;
      wr_ptr_d              = rsp_ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rsp_ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({cap_vld_q, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    haz_addr_d = haz_addr_q;
    for (int i = 0; i < WRITE_LATENCY; i++) begin
      haz_age_d[i] = (haz_age_q[i] != {AGW{1'b0}}) ? haz_age_q[i] - AGW'(1) : {AGW{1'b0}};
    end
    if (accept_s && bus.i_cmd_we) begin
      haz_age_d[haz_ptr_q]  = AGW'(WRITE_LATENCY);
      haz_addr_d[haz_ptr_q] = bus.i_cmd_addr;
      haz_ptr_d             = haz_ptr_inc(haz_ptr_q);
    end else begin
      haz_ptr_d = haz_ptr_q;
    end
  end

  // State registers; reset drops every pending read and hazard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_din_q   <= {DATA_WIDTH{1'b0}};
      trk_vld_q   <= {READ_LATENCY{1'b0}};
      trk_addr_q  <= '{default: {ADDR_WIDTH{1'b0}}};
      cap_vld_q   <= 1'b0;
      cap_addr_q  <= {ADDR_WIDTH{1'b0}};
      cap_data_q  <= {DATA_WIDTH{1'b0}};
      fifo_data_q <= '{default: {DATA_WIDTH{1'b0}}};
      fifo_addr_q <= '{default: {ADDR_WIDTH{1'b0}}};
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      haz_age_q   <= '{default: {AGW{1'b0}}};
      haz_addr_q  <= '{default: {ADDR_WIDTH{1'b0}}};
      haz_ptr_q   <= {HPW{1'b0}};
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      trk_vld_q   <= trk_vld_d;
      trk_addr_q  <= trk_addr_d;
      cap_vld_q   <= cap_vld_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      haz_age_q   <= haz_age_d;
      haz_addr_q  <= haz_addr_d;
      haz_ptr_q   <= haz_ptr_d;
    end
  end

  assign bus.o_cmd_ready = cmd_ready_s;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_din   = mem_din_q;
  assign bus.o_rsp_valid = rsp_valid_s;
  assign bus.o_rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.o_rsp_addr  = fifo_addr_q[rd_ptr_q];
  assign bus.o_busy      = (inflight_s != {CW{1'b0}}) | rsp_valid_s | haz_live_s;
endmodule

// File: tb/tb_bank_port_initiator.sv
// Directed bench for bank_port_initiator with a behavioural RAM port model.
module tb_bank_port_initiator;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 3;
  localparam int WL = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [DW-1:0] rd_q [$];
  logic [AW-1:0] ra_q [$];
  logic [DW-1:0] ram  [0:(1<<AW)-1] = '{default: 8'h00};
  logic [DW-1:0] pipe [RL] = '{default: 8'h00};
  logic [AW-1:0] bank_addr [4] = '{12'h000, 12'h400, 12'h800, 12'hC00};
  logic [DW-1:0] bank_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  bank_port_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bank_port_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
    .WRITE_LATENCY(WL), .RSP_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM port: write at the end of the strobe cycle, read data valid RL cycles after the strobe.
  always @(posedge clk) begin
    if (bus.o_mem_en && bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_din;
    pipe[0] <= (bus.o_mem_en && !bus.o_mem_we) ? ram[bus.o_mem_addr] : 8'h00;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_mem_dout = pipe[RL-1];

  // Record every consumed response.
  always @(negedge clk) begin
    if (!rst && bus.o_rsp_valid && bus.i_rsp_ready) begin
      rd_q.push_back(bus.o_rsp_data);
      ra_q.push_back(bus.o_rsp_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int stalls);
    bit got;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_wdata = data;
    bus.i_cmd_valid = 1'b1;
    stalls = 0;
    got    = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) got = 1'b1;
      else stalls++;
    end
    chk("cmd_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    if (got) begin
      chk("mem_en", 32'(bus.o_mem_en), 32'd1);
      chk("mem_we", 32'(bus.o_mem_we), 32'(we));
      chk("mem_addr", 32'(bus.o_mem_addr), 32'(addr));
      if (we) chk("mem_din", 32'(bus.o_mem_din), 32'(data));
    end
  endtask

  task automatic wait_rsp(input int n, output int lat);
    lat = 0;
    while (rd_q.size() < n && lat < 80) begin
      @(negedge clk);
      #1;
      if (rd_q.size() < n) lat++;
    end
    chk("rsp_count", 32'(rd_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vecs [12];
    int stalls, lat, hits;
    logic [DW-1:0] exp_d [6];
    logic [AW-1:0] exp_a [6];

    vecs[0]  = '{we: 1'b1, addr: 12'h000, data: 8'h11, stall: 0};
    vecs[1]  = '{we: 1'b1, addr: 12'h400, data: 8'h22, stall: 0};
    vecs[2]  = '{we: 1'b1, addr: 12'h800, data: 8'h33, stall: 0};
    vecs[3]  = '{we: 1'b1, addr: 12'hC00, data: 8'h44, stall: 0};
    vecs[4]  = '{we: 1'b0, addr: 12'hC00, data: 8'h44, stall: 2};
    vecs[5]  = '{we: 1'b0, addr: 12'h000, data: 8'h11, stall: 0};
    vecs[6]  = '{we: 1'b1, addr: 12'h805, data: 8'hA5, stall: 0};
    vecs[7]  = '{we: 1'b0, addr: 12'h805, data: 8'hA5, stall: 2};
    vecs[8]  = '{we: 1'b0, addr: 12'h400, data: 8'h22, stall: 0};
    vecs[9]  = '{we: 1'b1, addr: 12'hFFF, data: 8'h5A, stall: 0};
    vecs[10] = '{we: 1'b0, addr: 12'hFFF, data: 8'h5A, stall: 2};
    vecs[11] = '{we: 1'b0, addr: 12'h7FF, data: 8'h00, stall: 0};

    // Reset state
    rst = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = 1'b1;
    bus.i_cmd_addr  = 12'h000;
    bus.i_cmd_wdata = 8'h00;
    bus.i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_mem_din", 32'(bus.o_mem_din), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.o_rsp_data), 32'd0);
    chk("rst_rsp_addr", 32'(bus.o_rsp_addr), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table of single commands: stall cycles, read data, address and latency
    for (int i = 0; i < 12; i++) begin
      rd_q.delete();
      ra_q.delete();
      issue(vecs[i].we, vecs[i].addr, vecs[i].we ? vecs[i].data : 8'h00, stalls);
      chk("vec_stall", 32'(stalls), 32'(vecs[i].stall));
      if (!vecs[i].we) begin
        wait_rsp(1, lat);
        chk("vec_latency", 32'(lat), 32'(RL + 2));
        chk("vec_rsp_data", 32'(rd_q[0]), 32'(vecs[i].data));
        chk("vec_rsp_addr", 32'(ra_q[0]), 32'(vecs[i].addr));
      end
    end

    // Cross-bank streaming reads
    rd_q.delete();
    ra_q.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, bank_addr[i], 8'h00, stalls);
      chk("stream_stall", 32'(stalls), 32'd0);
    end
    wait_rsp(4, lat);
    for (int i = 0; i < 4; i++) begin
      chk("stream_data", 32'(rd_q[i]), 32'(bank_data[i]));
      chk("stream_addr", 32'(ra_q[i]), 32'(bank_addr[i]));
    end

    // Backpressure: credits run out after RSP_DEPTH reads, writes still pass
    bus.i_rsp_ready = 1'b0;
    rd_q.delete();
    ra_q.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, bank_addr[i], 8'h00, stalls);
      chk("bp_accept_stall", 32'(stalls), 32'd0);
    end
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 12'h805;
    bus.i_cmd_valid = 1'b1;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_cmd_ready) hits++;
    end
    chk("bp_credit_stall", 32'(hits), 32'd0);
    chk("bp_busy", 32'(bus.o_busy), 32'd1);
    chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b1, 12'h3AB, 8'h77, stalls);
    chk("zero_credit_write_stall", 32'(stalls), 32'd0);
    bus.i_rsp_ready = 1'b1;
    issue(1'b0, 12'h805, 8'h00, stalls);
    issue(1'b0, 12'hFFF, 8'h00, stalls);
    wait_rsp(6, lat);
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
    exp_a = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'h805, 12'hFFF};
    for (int i = 0; i < 6; i++) begin
      chk("bp_data", 32'(rd_q[i]), 32'(exp_d[i]));
      chk("bp_addr", 32'(ra_q[i]), 32'(exp_a[i]));
    end

    // Hazard re-arm: second write to the same address restarts the window
    rd_q.delete();
    ra_q.delete();
    issue(1'b1, 12'h123, 8'h01, stalls);
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 12'h123;
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    chk("rearm_early_ready", 32'(bus.o_cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b1, 12'h123, 8'h02, stalls);
    chk("rearm_write_stall", 32'(stalls), 32'd0);
    issue(1'b0, 12'h123, 8'h00, stalls);
    chk("rearm_read_stall", 32'(stalls), 32'd2);
    wait_rsp(1, lat);
    chk("rearm_data", 32'(rd_q[0]), 32'h02);

    // Reset with two reads in flight
    rd_q.delete();
    ra_q.delete();
    issue(1'b0, 12'h000, 8'h00, stalls);
    issue(1'b0, 12'h400, 8'h00, stalls);
    chk("flight_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("async_busy", 32'(bus.o_busy), 32'd0);
    chk("async_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("async_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_rsp_valid) hits++;
    end
    chk("post_rst_no_rsp", 32'(hits), 32'd0);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("post_rst_ready2", 32'(bus.o_cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bank_port_initiator.md
Name: bank_port_initiator

Overview:
- Initiator-side engine that drives one port (A or B) of the multi-bank dual-port RAM.
- Accepts read/write commands over a valid/ready handshake and issues them as registered en/we/addr/din strobes.
- Waits out the RAM's fixed READ_LATENCY, captures the returned data and hands it back on a backpressurable response channel.
- Blocks reads of an address whose write has not yet committed (WRITE_LATENCY window), so a client sees read-after-write coherency.

Parameters:
- ADDR_WIDTH, 12: command/memory address width, including bank-select MSBs.
- DATA_WIDTH, 8: data width.
- READ_LATENCY, 3: cycles from the memory-port read strobe to valid i_mem_dout; legal range ≥1.
- WRITE_LATENCY, 3: cycles a written address stays hazardous after command acceptance; legal range ≥1.
- RSP_DEPTH, 4: response buffer entries, which is also the maximum number of reads in flight; legal range ≥1.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when valid&&ready at rising edge.
- i_cmd_we  in  1  1=write, 0=read.
- i_cmd_addr  in  ADDR_WIDTH  command address.
- i_cmd_wdata  in  DATA_WIDTH  write data.
- o_mem_en  out  1  RAM port enable.
- o_mem_we  out  1  RAM port write enable.
- o_mem_addr  out  ADDR_WIDTH  RAM port address.
- o_mem_din  out  DATA_WIDTH  RAM port write data.
- i_mem_dout  in  DATA_WIDTH  RAM port read data.
- o_rsp_valid  out  1  read response available.
- i_rsp_ready  in  1  response consumed when valid&&ready.
- o_rsp_data  out  DATA_WIDTH  read data.
- o_rsp_addr  out  ADDR_WIDTH  address the response belongs to.
- o_busy  out  1  any read in flight, buffered response, or live write hazard.

Behaviour:
- Reset (async assert, sync release):
  - o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_din=0.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_addr=0, o_busy=0.
  - o_cmd_ready=0 while i_rst is high.
  - In-flight reads, the response buffer and the hazard tracker are all cleared. Reset mid-operation silently drops pending reads; no stale response may appear after release.
- Issue timing:
  - A command accepted at edge T drives o_mem_en=1, o_mem_we=i_cmd_we, o_mem_addr and o_mem_din for exactly one cycle after T.
  - o_mem_en=0 in every other cycle. o_mem_din holds its last value when unused.
  - Back-to-back acceptance gives back-to-back strobes, one command per cycle maximum.
- Read return:
  - A read strobe in cycle C has its data sampled from i_mem_dout at the end of cycle C+READ_LATENCY and pushed into the response FIFO with its address.
  - The tracking shift register is READ_LATENCY deep and carries a valid bit plus address.
  - Minimum accept-to-o_rsp_valid latency is READ_LATENCY+2 cycles.
- Response FIFO:
  - RSP_DEPTH entries, in order, first-word-fall-through. o_rsp_data and o_rsp_addr are stable while o_rsp_valid && !i_rsp_ready.
  - Push and pop in the same cycle keep the occupancy unchanged.
- Credit rule:
  - credits = RSP_DEPTH - (reads in flight + FIFO occupancy).
  - A read is accepted only if credits > 0, so the FIFO can never overflow and no dropped data is permitted.
  - Writes ignore credits.
- Hazard tracker:
  - WRITE_LATENCY entries, each holding an address and an age.
  - An accepted write loads an entry with age=WRITE_LATENCY. Each age decrements every cycle and the entry is dead at 0.
  - A read is stalled (o_cmd_ready=0) while any live entry matches the full i_cmd_addr. Net effect: a read of address X written at edge T is accepted no earlier than edge T+WRITE_LATENCY.
  - Writes never stall on hazards. A write to the same address re-arms the age.
- o_cmd_ready, combinational from state and i_cmd_*:
  - Ready = !i_rst && (i_cmd_we || (credits>0 && !hazard_match)).
  - o_cmd_ready does not depend on i_rsp_ready in the same cycle.
- o_busy: OR of any in-flight valid, FIFO non-empty, and any live hazard entry.
- Response ordering: responses are in acceptance order. A read's response carries data reflecting every write accepted before it.

Test Plan:
- Single write then read: write addr 0x805, data 0xA5, accepted at cycle 10; read 0x805 offered at cycle 11 → o_cmd_ready=0 on cycles 11–12, read accepted at 13; o_rsp_valid at 13+READ_LATENCY+2=18 with data 0xA5, addr 0x805.
- Cross-bank streaming: write 0x000, 0x400, 0x800, 0xC00 with data 0x11/22/33/44, then read all four back-to-back with i_rsp_ready=1 → four o_mem_en read strobes in consecutive cycles; responses in order 0x11, 0x22, 0x33, 0x44.
- Backpressure: i_rsp_ready=0, issue 6 reads to distinct written addresses → exactly 4 accepted, o_cmd_ready=0 thereafter; raising i_rsp_ready drains 4 responses in order, with the remaining 2 then accepted and returned.
- Writes under full credits: with credits=0, offer a write → accepted immediately, o_mem_we=1 next cycle.
- Reset mid-flight: 2 reads in flight, assert i_rst for 1 cycle → all outputs 0 asynchronously; after release no o_rsp_valid for 10 cycles, o_busy=0, o_cmd_ready=1.
- Hazard re-arm: write 0x123 at cycle 20, write 0x123 again at cycle 22, read 0x123 offered from 21 → accepted at 25, returns the second write's data.
